// File: rtl/register_file_mp.sv
// register_file_mp: parametrised multi-port register file.
// Registered reads with optional same-cycle write bypass, highest-index
// write-port priority with a conflict pulse, optional hardwired-zero
// register 0, and a clear sweep over every register after reset.
module register_file_mp #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS),  // derived; leave at default
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_RD-1:0]            read_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
  output logic [NUM_RD-1:0]            rvalid,
  input  logic [NUM_WR-1:0]            write_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] waddr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wdata,
  output logic                         ready,
  output logic                         wr_conflict
);

  // One extra bit so NUM_REGS itself is representable for range checks.
  localparam logic [ADDR_WIDTH:0]   REG_LIMIT = (ADDR_WIDTH+1)'(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] LAST_REG  = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clear_ptr;
  logic [DATA_WIDTH-1:0]   rf [NUM_REGS];

  logic [ADDR_WIDTH-1:0]   wa [NUM_WR];
  logic [DATA_WIDTH-1:0]   wd [NUM_WR];
  logic [NUM_WR-1:0]       wr_in_range;
  logic [NUM_WR-1:0]       wr_commit;
  logic                    conflict;

  logic [ADDR_WIDTH-1:0]   ra [NUM_RD];
  logic [DATA_WIDTH-1:0]   rd_val [NUM_RD];

  // Unpack write ports, qualify them, and detect same-address conflicts.
  // Writes to register 0 with ZERO_REG still count toward a conflict even
  // though they never commit.
  always_comb begin
    conflict = 1'b0;
    for (int unsigned p = 0; p < NUM_WR; p++) begin
      wa[p]          = waddr[p*ADDR_WIDTH +: ADDR_WIDTH];
      wd[p]          = wdata[p*DATA_WIDTH +: DATA_WIDTH];
      wr_in_range[p] = write_en[p] && ({1'b0, wa[p]} < REG_LIMIT);
      wr_commit[p]   = wr_in_range[p] && !((ZERO_REG != 0) && (wa[p] == '0));
    end
    for (int unsigned p = 0; p < NUM_WR; p++) begin
      for (int unsigned q = p + 1; q < NUM_WR; q++) begin
        if (wr_in_range[p] && wr_in_range[q] && (wa[p] == wa[q])) begin
          conflict = 1'b1;
        end
      end
    end
  end

  // Read data selection: out-of-range and hardwired zero first, then array
  // contents, overridden by the highest-index committing write when bypassing.
  always_comb begin
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      ra[i]     = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      rd_val[i] = '0;
      if (({1'b0, ra[i]} < REG_LIMIT) && !((ZERO_REG != 0) && (ra[i] == '0))) begin
        rd_val[i] = rf[ra[i]];
        if (BYPASS != 0) begin
          for (int unsigned p = 0; p < NUM_WR; p++) begin
            if (wr_commit[p] && (wa[p] == ra[i])) begin
              rd_val[i] = wd[p];
            end
          end
        end
      end
    end
  end

  // Register array: sweep clear in INIT, port writes in RUN (later ports win).
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT) begin
        rf[clear_ptr] <= '0;
      end else begin
        for (int unsigned p = 0; p < NUM_WR; p++) begin
          if (wr_commit[p]) begin
            rf[wa[p]] <= wd[p];
          end
        end
      end
    end
  end

  // Control FSM with registered read outputs, ready and conflict pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= INIT;
      clear_ptr   <= '0;
      ready       <= 1'b0;
      rvalid      <= '0;
      rdata       <= '0;
      wr_conflict <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          clear_ptr   <= clear_ptr + 1'b1;
          rvalid      <= '0;
          wr_conflict <= 1'b0;
          if (clear_ptr == LAST_REG) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          wr_conflict <= conflict;
          rvalid      <= read_en;
          for (int unsigned i = 0; i < NUM_RD; i++) begin
            if (read_en[i]) begin
              rdata[i*DATA_WIDTH +: DATA_WIDTH] <= rd_val[i];
            end
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: three register_file_mp variants driven in lockstep
// (32 regs bypass, 32 regs no bypass, 24 regs bypass) against a behavioural
// model with a one-cycle scoreboard, plus a hand-derived vector table.
module tb_register_file_mp;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   read_en;
  logic [9:0]   raddr;
  logic [1:0]   write_en;
  logic [9:0]   waddr;
  logic [127:0] wdata;

  logic [127:0] rd_o  [3];
  logic [1:0]   rv_o  [3];
  logic         rdy_o [3];
  logic         cf_o  [3];

  always #5 clk = ~clk;

  register_file_mp #(.NUM_REGS(32), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .read_en(read_en), .raddr(raddr),
    .rdata(rd_o[0]), .rvalid(rv_o[0]), .write_en(write_en), .waddr(waddr),
    .wdata(wdata), .ready(rdy_o[0]), .wr_conflict(cf_o[0]));

  register_file_mp #(.NUM_REGS(32), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .read_en(read_en), .raddr(raddr),
    .rdata(rd_o[1]), .rvalid(rv_o[1]), .write_en(write_en), .waddr(waddr),
    .wdata(wdata), .ready(rdy_o[1]), .wr_conflict(cf_o[1]));

  register_file_mp #(.NUM_REGS(24), .BYPASS(1)) dut_c (
    .clk(clk), .reset(reset), .read_en(read_en), .raddr(raddr),
    .rdata(rd_o[2]), .rvalid(rv_o[2]), .write_en(write_en), .waddr(waddr),
    .wdata(wdata), .ready(rdy_o[2]), .wr_conflict(cf_o[2]));

  int nregs [3] = '{32, 32, 24};
  int bypass[3] = '{1, 0, 1};

  logic [63:0] mem     [3][32];
  logic [63:0] last_rd [3][2];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0][1:0][63:0] rd;
    logic [2:0][1:0]       rv;
    logic [2:0]            cf;
  } exp_t;

  exp_t sb_q[$];

  typedef struct packed {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [63:0] wd0, wd1;
    logic [1:0]  re;
    logic [4:0]  ra0, ra1;
    logic [63:0] x0, x1;
    logic [1:0]  xv;
    logic        xc;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_read(input int d, input int a);
    if (a >= nregs[d] || a == 0) return 64'h0;
    if (bypass[d] != 0) begin
      for (int p = 1; p >= 0; p--) begin
        if (write_en[p] && int'(waddr[p*5 +: 5]) == a) return wdata[p*64 +: 64];
      end
    end
    return mem[d][a];
  endfunction

  // Predict this cycle's outputs, commit writes to the model, clock, compare.
  task automatic step(input string tag);
    exp_t e;
    int   a;
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 2; i++) begin
        e.rv[d][i] = read_en[i];
        if (read_en[i]) last_rd[d][i] = model_read(d, int'(raddr[i*5 +: 5]));
        e.rd[d][i] = last_rd[d][i];
      end
      e.cf[d] = (write_en == 2'b11) && (waddr[4:0] == waddr[9:5]) &&
                (int'(waddr[4:0]) < nregs[d]);
    end
    sb_q.push_back(e);
    for (int d = 0; d < 3; d++) begin
      for (int p = 0; p < 2; p++) begin
        a = int'(waddr[p*5 +: 5]);
        if (write_en[p] && a < nregs[d] && a != 0) mem[d][a] = wdata[p*64 +: 64];
      end
    end
    @(posedge clk); #1;
    e = sb_q.pop_front();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s dut%0d rdata0", tag, d), rd_o[d][63:0],   e.rd[d][0]);
      chk($sformatf("%s dut%0d rdata1", tag, d), rd_o[d][127:64], e.rd[d][1]);
      chk($sformatf("%s dut%0d rvalid", tag, d), {62'd0, rv_o[d]}, {62'd0, e.rv[d]});
      chk($sformatf("%s dut%0d wr_conflict", tag, d), {63'd0, cf_o[d]}, {63'd0, e.cf[d]});
    end
  endtask

  // Hold reset n cycles with traffic present, then run and check the sweep.
  task automatic do_reset(input int n, input string tag);
    reset    = 1'b1;
    read_en  = 2'b11;
    raddr    = {5'd7, 5'd5};
    write_en = 2'b11;
    waddr    = {5'd5, 5'd5};
    wdata    = {64'h1111, 64'h2222};
    for (int d = 0; d < 3; d++) begin
      for (int r = 0; r < 32; r++) mem[d][r] = 64'h0;
      last_rd[d][0] = 64'h0;
      last_rd[d][1] = 64'h0;
    end
    repeat (n) begin
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("%s rst dut%0d ready", tag, d), {63'd0, rdy_o[d]}, 64'h0);
        chk($sformatf("%s rst dut%0d rvalid", tag, d), {62'd0, rv_o[d]}, 64'h0);
        chk($sformatf("%s rst dut%0d rdata0", tag, d), rd_o[d][63:0], 64'h0);
        chk($sformatf("%s rst dut%0d rdata1", tag, d), rd_o[d][127:64], 64'h0);
        chk($sformatf("%s rst dut%0d wr_conflict", tag, d), {63'd0, cf_o[d]}, 64'h0);
      end
    end
    reset = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      if (k == 9) write_en = 2'b00;
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("%s sweep%0d dut%0d ready", tag, k, d), {63'd0, rdy_o[d]},
            (k >= nregs[d]) ? 64'h1 : 64'h0);
        chk($sformatf("%s sweep%0d dut%0d rvalid", tag, k, d), {62'd0, rv_o[d]},
            (k > nregs[d]) ? 64'h3 : 64'h0);
        chk($sformatf("%s sweep%0d dut%0d rdata0", tag, k, d), rd_o[d][63:0], 64'h0);
        chk($sformatf("%s sweep%0d dut%0d wr_conflict", tag, k, d), {63'd0, cf_o[d]}, 64'h0);
      end
    end
    read_en = 2'b00;
    for (int r = 0; r < 32; r++) chk($sformatf("%s dut0 rf[%0d]", tag, r), dut_a.rf[r], 64'h0);
    for (int r = 0; r < 24; r++) chk($sformatf("%s dut2 rf[%0d]", tag, r), dut_c.rf[r], 64'h0);
  endtask

  initial begin
    //            we     wa0    wa1    wd0                    wd1        re     ra0    ra1    x0 (dut0)              x1                     xv     xc
    vecs[0]  = '{2'b01, 5'd5,  5'd0,  64'hDEAD_BEEF_0000_0001, 64'h0,    2'b00, 5'd0,  5'd0,  64'h0,                 64'h0,                 2'b00, 1'b0};
    vecs[1]  = '{2'b00, 5'd0,  5'd0,  64'h0,                 64'h0,      2'b11, 5'd5,  5'd5,  64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001, 2'b11, 1'b0};
    vecs[2]  = '{2'b01, 5'd7,  5'd0,  64'h1234,              64'h0,      2'b11, 5'd7,  5'd5,  64'h1234,              64'hDEAD_BEEF_0000_0001, 2'b11, 1'b0};
    vecs[3]  = '{2'b00, 5'd0,  5'd0,  64'h0,                 64'h0,      2'b01, 5'd7,  5'd0,  64'h1234,              64'hDEAD_BEEF_0000_0001, 2'b01, 1'b0};
    vecs[4]  = '{2'b11, 5'd9,  5'd9,  64'hAAAA,              64'hBBBB,   2'b00, 5'd0,  5'd0,  64'h1234,              64'hDEAD_BEEF_0000_0001, 2'b00, 1'b1};
    vecs[5]  = '{2'b00, 5'd0,  5'd0,  64'h0,                 64'h0,      2'b11, 5'd9,  5'd9,  64'hBBBB,              64'hBBBB,              2'b11, 1'b0};
    vecs[6]  = '{2'b10, 5'd0,  5'd0,  64'h0,                 64'hFFFF,   2'b11, 5'd0,  5'd9,  64'h0,                 64'hBBBB,              2'b11, 1'b0};
    vecs[7]  = '{2'b00, 5'd0,  5'd0,  64'h0,                 64'h0,      2'b11, 5'd0,  5'd30, 64'h0,                 64'h0,                 2'b11, 1'b0};
    vecs[8]  = '{2'b11, 5'd30, 5'd30, 64'h77,                64'h88,     2'b01, 5'd30, 5'd0,  64'h88,                64'h0,                 2'b01, 1'b1};
    vecs[9]  = '{2'b00, 5'd0,  5'd0,  64'h0,                 64'h0,      2'b11, 5'd30, 5'd30, 64'h88,                64'h88,                2'b11, 1'b0};
    vecs[10] = '{2'b11, 5'd0,  5'd0,  64'h5,                 64'h6,      2'b00, 5'd0,  5'd0,  64'h88,                64'h88,                2'b00, 1'b1};
    vecs[11] = '{2'b11, 5'd3,  5'd23, 64'h55,                64'h66,     2'b11, 5'd23, 5'd3,  64'h66,                64'h55,                2'b11, 1'b0};

    do_reset(3, "init");

    for (int v = 0; v < 12; v++) begin
      write_en = vecs[v].we;
      waddr    = {vecs[v].wa1, vecs[v].wa0};
      wdata    = {vecs[v].wd1, vecs[v].wd0};
      read_en  = vecs[v].re;
      raddr    = {vecs[v].ra1, vecs[v].ra0};
      step($sformatf("vec%0d", v));
      chk($sformatf("vec%0d table rdata0", v), rd_o[0][63:0],   vecs[v].x0);
      chk($sformatf("vec%0d table rdata1", v), rd_o[0][127:64], vecs[v].x1);
      chk($sformatf("vec%0d table rvalid", v), {62'd0, rv_o[0]}, {62'd0, vecs[v].xv});
      chk($sformatf("vec%0d table wr_conflict", v), {63'd0, cf_o[0]}, {63'd0, vecs[v].xc});
    end

    // BYPASS=0 re-read of reg 7 returns the committed value.
    write_en = 2'b00;
    read_en  = 2'b01;
    raddr    = {5'd0, 5'd7};
    step("reread7");
    chk("reread7 dut1 rdata0", rd_o[1][63:0], 64'h1234);

    // Mid-run reset wipes reg 3 (0x55) and reg 23 (0x66).
    do_reset(2, "midrun");
    write_en = 2'b00;
    read_en  = 2'b11;
    raddr    = {5'd23, 5'd3};
    step("postrst");
    chk("postrst dut0 reg3", rd_o[0][63:0], 64'h0);
    chk("postrst dut2 reg23", rd_o[2][127:64], 64'h0);
    read_en = 2'b00;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
